// File: rtl/record_sequencer.sv
// Recording sequencer: captures ADC samples into consecutive SRAM words,
// with pause, stop and memory-full handling.
module record_sequencer #(
    parameter int              ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_BCLK,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_sample_valid,
    input  logic [15:0]       i_sample,
    output logic              o_record,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic [15:0]       o_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic [ADDR_W:0]   o_length,
    output logic              o_full,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_WRITE   = 3'd2,
        S_PAUSE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t state;

    assign o_state = state;

    // Write lasts a single cycle, so a stop/pause arriving during it is
    // simply applied on the transition out of S_WRITE.
    always_ff @(posedge i_BCLK) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_record    <= 1'b0;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_ADDR <= '0;
            o_SRAM_DQ   <= '0;
            o_length    <= '0;
            o_full      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    o_SRAM_WE_N <= 1'b1;
                    if (i_start) begin
                        state       <= S_CAPTURE;
                        o_record    <= 1'b1;
                        o_SRAM_ADDR <= '0;
                        o_length    <= '0;
                        o_full      <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (i_stop) begin
                        state    <= S_DONE;
                        o_record <= 1'b0;
                    end else if (i_pause) begin
                        state    <= S_PAUSE;
                        o_record <= 1'b0;
                    end else if (i_sample_valid) begin
                        state       <= S_WRITE;
                        o_SRAM_DQ   <= i_sample;
                        o_SRAM_WE_N <= 1'b0;
                    end
                end
                S_WRITE: begin
                    o_SRAM_WE_N <= 1'b1;
                    o_length    <= o_length + LEN_ONE;
                    // The address stays parked at MAX_ADDR once memory is full.
                    if (o_SRAM_ADDR == MAX_ADDR) begin
                        state    <= S_DONE;
                        o_full   <= 1'b1;
                        o_record <= 1'b0;
                    end else begin
                        o_SRAM_ADDR <= o_SRAM_ADDR + ADDR_ONE;
                        if (i_stop) begin
                            state    <= S_DONE;
                            o_record <= 1'b0;
                        end else if (i_pause) begin
                            state    <= S_PAUSE;
                            o_record <= 1'b0;
                        end else begin
                            state <= S_CAPTURE;
                        end
                    end
                end
                S_PAUSE: begin
                    o_SRAM_WE_N <= 1'b1;
                    if (i_stop) begin
                        state <= S_DONE;
                    end else if (i_pause) begin
                        state    <= S_CAPTURE;
                        o_record <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    o_record    <= 1'b0;
                    o_SRAM_WE_N <= 1'b1;
                end
            endcase
        end
    end

endmodule
